store_monitor: RTL

Bus-side responder for the single-cycle processor's data-memory write port. It watches `memwrite`/`dataadr`/`writedata` every cycle and logs each store as an (address, data) entry in a DEPTH-entry FIFO. A simulation harness or debug reader drains the log through a valid/ready port. A store to HALT_ADDR moves the block into a sticky HALTED state, which gives the bench a deterministic end-of-program signal.

---
 rtl/store_monitor.sv | 112 +++++++++++
 1 files changed

// File: rtl/store_monitor.sv
// Store log for the single-cycle processor's data-memory write port.
// Each store becomes an {addr, data} FIFO entry; a store to HALT_ADDR latches a sticky halt.
module store_monitor #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] HALT_ADDR = 32'h0000_FFFC,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_addr,
  output logic [31:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          halted,
  output logic [31:0]   halt_data,
  output logic [15:0]   store_total
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   halt_data_q, halt_data_d;
  logic [15:0]   store_total_q, store_total_d;

  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          cap, push, pop, empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = !empty && rd_ready;
  assign cap   = (state_q == RUN) && memwrite;
  // A full FIFO still accepts the store when the head leaves on the same edge.
  assign push  = cap && (!full || pop);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    halt_data_d   = halt_data_q;
    store_total_d = store_total_q;

    if (cap) begin
      if (store_total_q != 16'hFFFF) store_total_d = store_total_q + 16'd1;
      if (!push) overflow_d = 1'b1;
      if (dataadr == HALT_ADDR) begin
        state_d     = HALTED;
        halt_data_d = writedata;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      halt_data_q   <= '0;
      store_total_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      halt_data_q   <= halt_data_d;
      store_total_q <= store_total_d;
    end
  end

  // Storage is not reset; stale contents are hidden by the empty gating below.
  always_ff @(posedge clk) begin
    if (push && reset) begin
      addr_mem[wr_ptr_q] <= dataadr;
      data_mem[wr_ptr_q] <= writedata;
    end
  end

  assign rd_valid    = !empty;
  assign rd_addr     = empty ? 32'd0 : addr_mem[rd_ptr_q];
  assign rd_data     = empty ? 32'd0 : data_mem[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign halted      = (state_q == HALTED);
  assign halt_data   = halt_data_q;
  assign store_total = store_total_q;

endmodule
